// File: rtl/bbox_scanner.sv
// Bounding-box extractor: streams an interleaved frame out of word memory and reports the
// min/max coordinates and the count of pixels that have any channel below a threshold.
module bbox_scanner #(
  parameter int MAX_W     = 2048,
  parameter int MAX_H     = 2048,
  parameter int CHANNELS  = 3,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int ROW_ALIGN = 4,
  localparam int XW  = $clog2(MAX_W),
  localparam int YW  = $clog2(MAX_H),
  localparam int PCW = $clog2(MAX_W * MAX_H + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XW:0]       img_w,
  input  logic [YW:0]       img_h,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] threshold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [XW-1:0]     x_min,
  output logic [XW-1:0]     x_max,
  output logic [YW-1:0]     y_min,
  output logic [YW-1:0]     y_max,
  output logic [PCW-1:0]    pix_count,
  output logic [1:0]        dbg_state
);

  // Handshakes: start is a one-cycle request honoured only in IDLE/DONE; rd_en/addr is an
  // unthrottled request stream and each request's rddata arrives exactly RD_LAT cycles later.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = XW + YW + 2;
  localparam logic [XW:0]   MAX_W_V = (XW + 1)'(MAX_W);
  localparam logic [YW:0]   MAX_H_V = (YW + 1)'(MAX_H);
  localparam logic [CW-1:0] LAST_C  = CW'(CHANNELS - 1);

  logic [1:0]        state_q, state_d;
  logic [XW:0]       w_q, w_d;
  logic [YW:0]       h_q, h_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     c_q, c_d;
  logic              pix_or_q, pix_or_d;
  logic              found_q, found_d;
  logic [XW-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]     ymin_q, ymin_d, ymax_q, ymax_d;
  logic [PCW-1:0]    cnt_q, cnt_d;

  logic [RD_LAT-1:0] tv_q;
  logic [TW-1:0]     tag_q [RD_LAT];

  logic [XW:0]       w_clamp;
  logic [YW:0]       h_clamp;
  logic [ADDR_W-1:0] row_words;
  logic [ADDR_W-1:0] stride_new;
  logic              last_c, last_x, last_y, last_rd;
  logic              t_v, t_fin, t_lc;
  logic [XW-1:0]     t_x;
  logic [YW-1:0]     t_y;
  logic              hit, pix_fg;

  always_comb begin
    w_clamp    = (img_w > MAX_W_V) ? MAX_W_V : img_w;
    h_clamp    = (img_h > MAX_H_V) ? MAX_H_V : img_h;
    row_words  = ADDR_W'(w_clamp) * ADDR_W'(CHANNELS);
    stride_new = ((row_words + ADDR_W'(ROW_ALIGN - 1)) / ADDR_W'(ROW_ALIGN)) * ADDR_W'(ROW_ALIGN);
  end

  assign last_c  = (c_q == LAST_C);
  assign last_x  = ({1'b0, x_q} == w_q - 1'b1);
  assign last_y  = ({1'b0, y_q} == h_q - 1'b1);
  assign last_rd = last_c & last_x & last_y;

  // Oldest tag lines up with the rddata currently on the bus.
  assign t_v = tv_q[RD_LAT-1];
  assign {t_fin, t_lc, t_y, t_x} = tag_q[RD_LAT-1];

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    thr_d    = thr_q;
    stride_d = stride_q;
    row_d    = row_q;
    addr_d   = addr_q;
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    pix_or_d = pix_or_q;
    found_d  = found_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    cnt_d    = cnt_q;

    hit    = (rddata < thr_q);
    pix_fg = t_v & t_lc & (pix_or_q | hit);
    if (t_v) pix_or_d = t_lc ? 1'b0 : (pix_or_q | hit);

    if (pix_fg) begin
      if (!found_q) begin
        xmin_d = t_x;
        xmax_d = t_x;
        ymin_d = t_y;
        ymax_d = t_y;
      end else begin
        if (t_x < xmin_q) xmin_d = t_x;
        if (t_x > xmax_q) xmax_d = t_x;
        if (t_y < ymin_q) ymin_d = t_y;
        if (t_y > ymax_q) ymax_d = t_y;
      end
      found_d = 1'b1;
      cnt_d   = cnt_q + PCW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d      = w_clamp;
          h_d      = h_clamp;
          thr_d    = threshold;
          stride_d = stride_new;
          row_d    = base_addr;
          addr_d   = base_addr;
          x_d      = '0;
          y_d      = '0;
          c_d      = '0;
          pix_or_d = 1'b0;
          found_d  = 1'b0;
          xmin_d   = '0;
          xmax_d   = '0;
          ymin_d   = '0;
          ymax_d   = '0;
          cnt_d    = '0;
          state_d  = (w_clamp == '0 || h_clamp == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (!last_c) begin
          c_d    = c_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end else if (!last_x) begin
          c_d    = '0;
          x_d    = x_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end else begin
          c_d    = '0;
          x_d    = '0;
          y_d    = y_q + 1'b1;
          row_d  = row_q + stride_q;
          addr_d = row_q + stride_q;
        end
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (t_v && t_fin) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      thr_q    <= '0;
      stride_q <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      pix_or_q <= 1'b0;
      found_q  <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      cnt_q    <= '0;
      tv_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      thr_q    <= thr_d;
      stride_q <= stride_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      pix_or_q <= pix_or_d;
      found_q  <= found_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      cnt_q    <= cnt_d;
      tv_q[0]  <= (state_q == S_SCAN);
      tag_q[0] <= {last_rd, last_c, y_q, x_q};
      for (int i = 1; i < RD_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rd_en     = (state_q == S_SCAN);
  assign addr      = addr_q;
  assign busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign found     = found_q;
  assign x_min     = xmin_q;
  assign x_max     = xmax_q;
  assign y_min     = ymin_q;
  assign y_max     = ymax_q;
  assign pix_count = cnt_q;
  assign dbg_state = state_q;

endmodule
